// File: rtl/dot4x_phase_sequencer.sv
// Lock-qualified reset release and 32-cycle phi phase generator running on the
// 4x dot clock. Every output is registered one cycle behind the state/phase it reports.
module dot4x_phase_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic       clk_dot4x,
    input  logic       reset,
    input  logic       locked,
    input  logic       clear_lost,
    output logic       rst_out,
    output logic       dot_en,
    output logic       clk_phi,
    output logic       phi_rise,
    output logic       phi_fall,
    output logic [4:0] phase,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        sync1_q;
    logic        locked_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  pos_q, pos_d;
    logic        rst_out_q, rst_out_d;
    logic        dot_en_q, dot_en_d;
    logic        clk_phi_q, clk_phi_d;
    logic        phi_rise_q, phi_rise_d;
    logic        phi_fall_q, phi_fall_d;
    logic [4:0]  phase_q, phase_d;
    logic        lock_lost_q, lock_lost_d;
    logic        lock_set;
    logic        run_ok;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        lock_set = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                pos_d = '0;
                if (locked_s_q) state_d = STABILIZE;
            end
            STABILIZE: begin
                pos_d = '0;
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (!locked_s_q) begin
                    state_d  = WAIT_LOCK;
                    pos_d    = '0;
                    lock_set = 1'b1;
                end else begin
                    pos_d = pos_q + 5'd1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                pos_d   = '0;
            end
        endcase

        // Gating on locked_s lets rst_out rise on the same edge the FSM leaves RUN.
        run_ok      = (state_q == RUN) && locked_s_q;
        rst_out_d   = !run_ok;
        phase_d     = run_ok ? pos_q : '0;
        dot_en_d    = run_ok && (pos_q[1:0] == 2'b11);
        clk_phi_d   = run_ok && pos_q[4];
        phi_rise_d  = run_ok && (pos_q == 5'd16);
        // rst_out_q still high marks the very first RUN cycle, which gets no fall pulse.
        phi_fall_d  = run_ok && (pos_q == 5'd0) && !rst_out_q;
        lock_lost_d = lock_set | (lock_lost_q & ~clear_lost);
    end

    always_ff @(posedge clk_dot4x or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            cnt_q       <= '0;
            pos_q       <= '0;
            rst_out_q   <= 1'b1;
            dot_en_q    <= 1'b0;
            clk_phi_q   <= 1'b0;
            phi_rise_q  <= 1'b0;
            phi_fall_q  <= 1'b0;
            phase_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= locked;
            locked_s_q  <= sync1_q;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            rst_out_q   <= rst_out_d;
            dot_en_q    <= dot_en_d;
            clk_phi_q   <= clk_phi_d;
            phi_rise_q  <= phi_rise_d;
            phi_fall_q  <= phi_fall_d;
            phase_q     <= phase_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign dot_en    = dot_en_q;
    assign clk_phi   = clk_phi_q;
    assign phi_rise  = phi_rise_q;
    assign phi_fall  = phi_fall_q;
    assign phase     = phase_q;
    assign lock_lost = lock_lost_q;

endmodule
